vga_fb_scanout: RTL
===================

Name: vga_fb_scanout

Overview:
- Pixel stage directly downstream of the VGA timing generator.
- Consumes raster coordinates, blanking and sync, and fetches a 4-bit palette index per pixel from a 2x-downscaled 320x240 framebuffer in synchronous RAM.
- Maps the index through a writable 16-entry 12-bit palette.
- Drives 4:4:4 RGB with hsync/vsync/blank delayed to stay pixel-aligned with the colour.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SCALE_SHIFT, 1, log2 of the pixel replication factor. The framebuffer is (H_ACTIVE>>SCALE_SHIFT) x (V_ACTIVE>>SCALE_SHIFT).
- ADDR_W, 17, framebuffer address width. Must cover FB width x FB height (76800 at defaults).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  one-clk strobe per pixel period; all pixel pipeline stages advance only when high
- in_x  in  10  current raster column
- in_y  in  10  current raster line
- in_blank  in  1  timing generator blanking
- in_hsync  in  1  horizontal sync
- in_vsync  in  1  vertical sync
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rd  out  1  framebuffer read strobe
- fb_data  in  4  palette index; valid exactly one clk after fb_rd
- pal_we  in  1  palette write enable
- pal_idx  in  4  palette write index
- pal_rgb  in  12  palette write data, {R,G,B}
- red / green / blue  out  4 each  colour outputs
- out_hsync / out_vsync / out_blank  out  1 each  delayed sync and blanking
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented

Behaviour:
- Reset (rst=1 at a clk edge): all outputs go to 0. Pipeline valid bits and the fetch-hold register clear. The palette loads a greyscale ramp: entry i = {i,i,i}.
- Stage 1, on pix_en:
  - active = !in_blank && in_x < H_ACTIVE && in_y < V_ACTIVE.
  - fb_addr = (in_y>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (in_x>>SCALE_SHIFT).
  - At defaults the multiply is implemented as (ys<<8)+(ys<<6), with all terms zero-extended to ADDR_W.
  - fb_rd = active, for exactly that one clk.
  - Register active, x, y and the three timing bits into stage 1.
- fb_rd and fb_addr are 0 on every clk where pix_en=0 or active=0.
- Fetch hold: on the clk after fb_rd, capture fb_data into hold_idx. hold_idx is held until the next capture.
- Stage 2, on pix_en:
  - Colour = pal[hold_idx] when the stage-1 active bit is set, else 12'h000.
  - out_hsync, out_vsync and out_blank take the stage-1 values.
  - Outputs are registered and held constant between pix_en strobes.
- Latency: inputs presented on pix_en number N appear on outputs on the clk after pix_en number N+1. All six outputs share this 2-strobe alignment.
- frame_start is high for one clk, on the clk where outputs update with stage-1 x=0, y=0, active=1. Otherwise it is 0.
- Palette write: on any clk with pal_we=1, pal[pal_idx] <= pal_rgb, independent of pix_en.
  - A stage-2 read of the same entry on the same clk returns the old value.
  - A write during rst is ignored.
- Boundaries:
  - x in 640..799 or y in 480..524 produces black and no fetch, even if in_blank is low.
  - in_x/in_y wrap to 0 is handled purely by coordinates; there is no internal counter.
  - pix_en on consecutive clks is legal; fb_data must still arrive one clk after fb_rd.
  - Reset mid-frame clears the pipeline. Output resumes aligned two strobes after the first post-reset pix_en. No stale colour is emitted.

Optional Feature:
- Macro: VGA_FB_SCANOUT_TEST_PATTERN_EN.
- Defined:
  - Adds input port pattern_en (1 bit).
  - While pattern_en=1, stage 1 forces fb_rd=0.
  - The stage-2 index is the registered in_x[9:6] instead of hold_idx, giving 64-px vertical bars with indices 0..9 through the palette.
  - Sync and blank timing are unchanged.
- Undefined: the pattern_en port and its logic are absent, and the index always comes from the framebuffer.

Test Plan:
- Reset, then pix_en every 10 clks with in_x=0, in_y=0, active, fb_data=4'h5. Expect fb_rd=1 with fb_addr=0. Expect RGB=12'h555 and a frame_start pulse on the clk after the second pix_en.
- in_x=639, in_y=479, active. Expect fb_addr=76799, i.e. 239*320+319.
- in_x=650, in_blank=0. Expect fb_rd=0 and RGB=0 two strobes later.
- Drive in_hsync=1 for strobes 656..751. Expect out_hsync high for exactly 96 strobes, shifted by 2 strobes, and colour/blank aligned.
- Write pal_we, pal_idx=3, pal_rgb=12'hF00 on the same clk stage 2 reads index 3. Expect old value 12'h333 now and 12'hF00 on the next strobe reading index 3.
- Assert rst for 1 clk mid-line at x=320. Expect all outputs 0 immediately. Expect the first non-black pixel two strobes after the next active pix_en. With the macro defined, pattern_en=1 at x=128 gives index 2, colour 12'h222, and fb_rd=0.

Source files
------------

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: pixel stage behind the VGA timing generator.
// It fetches a 4-bit palette index per pixel from a downscaled framebuffer
// held in synchronous RAM. The index goes through a writable 16 x 12-bit
// palette, and the block drives RGB444 with sync and blank kept
// pixel-aligned to the colour.
//
// Optional feature macro: VGA_FB_SCANOUT_TEST_PATTERN_EN
//   Adds input pattern_en. While pattern_en is high, fetches are suppressed
//   and the palette index becomes in_x[9:6], which draws 64-px vertical bars.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pix_en             one-clk strobe per pixel period; the pipeline advances on it
//   in_x, in_y         raster coordinates (10 bits each)
//   in_blank/hsync/vsync  timing generator controls
//   fb_addr, fb_rd     framebuffer read request (combinational, same clk as pix_en)
//   fb_data            palette index returned one clk after fb_rd
//   pal_we/idx/rgb     palette write port, {R,G,B}
//   red/green/blue     colour outputs, registered
//   out_hsync/vsync/blank  timing bits delayed by two strobes
//   frame_start        one-clk pulse when pixel (0,0) is presented
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  input  logic              in_blank,
  input  logic              in_hsync,
  input  logic              in_vsync,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [3:0]        fb_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_blank,
`ifdef VGA_FB_SCANOUT_TEST_PATTERN_EN
  input  logic              pattern_en,
`endif
  output logic              frame_start
);

  localparam int unsigned FB_W = H_ACTIVE >> SCALE_SHIFT;

  logic              w_active;
  logic              w_pat;
  logic              w_fetch;
  logic [9:0]        w_xs;
  logic [9:0]        w_ys;
  logic [ADDR_W-1:0] w_lin;
  logic [3:0]        w_fetch_idx;
  logic [3:0]        w_idx;

  logic              r_s1_active;
  logic              r_s1_pat;
  logic [9:0]        r_s1_x;
  logic [9:0]        r_s1_y;
  logic              r_s1_hsync;
  logic              r_s1_vsync;
  logic              r_s1_blank;
  logic              r_rd_d;
  logic [3:0]        r_hold_idx;
  logic [11:0]       r_pal [16];

`ifdef VGA_FB_SCANOUT_TEST_PATTERN_EN
  assign w_pat = pattern_en;
`else
  assign w_pat = 1'b0;
`endif

  // Stage 1 decode: visible pixel test and linear framebuffer address.
  assign w_active = !in_blank && (in_x < 10'(H_ACTIVE)) && (in_y < 10'(V_ACTIVE));
  assign w_xs     = in_x >> SCALE_SHIFT;
  assign w_ys     = in_y >> SCALE_SHIFT;

  generate
    if (FB_W == 320) begin : g_addr_shift
      // 320 = 256 + 64, so the row multiply becomes two shifts and an add.
      assign w_lin = (ADDR_W'(w_ys) << 8) + (ADDR_W'(w_ys) << 6) + ADDR_W'(w_xs);
    end else begin : g_addr_mul
      assign w_lin = ADDR_W'(32'(w_ys) * FB_W) + ADDR_W'(w_xs);
    end
  endgenerate

  // The read request is a one-clk strobe in the pix_en cycle, and it is zero otherwise.
  assign w_fetch = pix_en && w_active && !w_pat && !rst;
  assign fb_rd   = w_fetch;
  assign fb_addr = w_fetch ? w_lin : '0;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_active <= 1'b0;
      r_s1_pat    <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_blank  <= 1'b0;
    end else if (pix_en) begin
      r_s1_active <= w_active;
      r_s1_pat    <= w_pat;
      r_s1_x      <= in_x;
      r_s1_y      <= in_y;
      r_s1_hsync  <= in_hsync;
      r_s1_vsync  <= in_vsync;
      r_s1_blank  <= in_blank;
    end
  end

  // Fetch hold: capture RAM data in the clk after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_d     <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_rd_d <= w_fetch;
      if (r_rd_d) begin
        r_hold_idx <= fb_data;
      end
    end
  end

  // If the next strobe arrives in the capture clk, the data is still on
  // fb_data and has not reached the hold register yet, so forward it directly.
  assign w_fetch_idx = r_rd_d ? fb_data : r_hold_idx;
  assign w_idx       = r_s1_pat ? r_s1_x[9:6] : w_fetch_idx;

  // Palette: a greyscale ramp on reset. Writes are ignored while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= {3{4'(i)}};
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_rgb;
    end
  end

  // Stage 2: colour and delayed timing. A same-clk palette write is seen one strobe later.
  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      out_blank   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        {red, green, blue} <= r_s1_active ? r_pal[w_idx] : 12'h000;
        out_hsync          <= r_s1_hsync;
        out_vsync          <= r_s1_vsync;
        out_blank          <= r_s1_blank;
        frame_start        <= r_s1_active && (r_s1_x == 10'd0) && (r_s1_y == 10'd0);
      end
    end
  end

endmodule
